layer_sequencer: RTL and testbench

Top-level scheduler for the CNN inference pipeline: runs a fixed chain of layer engines (conv1, pool1, conv2, pool2, fc, ...) strictly in order. It issues a one-cycle start to each engine, waits for that engine's one-cycle done, then advances to the next. Each stage has a watchdog. Protocol violations are trapped, the run time is reported, and a single done pulse is raised when the whole chain completes.

---
 rtl/layer_sequencer.sv | 134 +++++++++++++
 tb/tb_layer_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Top-level scheduler for the CNN layer chain: launches each engine in order,
// waits for its done under a per-stage watchdog, traps protocol violations.
module layer_sequencer #(
    parameter int NUM_STAGES = 5,
    parameter int TIMEOUT    = 65536,
    parameter int STAGE_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  abort,
    input  logic                  clear,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [STAGE_W-1:0]    err_stage,
    output logic [STAGE_W-1:0]    cur_stage,
    output logic [31:0]           total_cycles
);
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [1:0]         ERR_NONE     = 2'b00;
    localparam logic [1:0]         ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0]         ERR_SPURIOUS = 2'b10;
    localparam logic [STAGE_W-1:0] LAST_STAGE   = STAGE_W'(NUM_STAGES - 1);
    localparam logic [WD_W-1:0]    WD_LIMIT     = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FINISH, S_ERROR} state_t;

    state_t                state_q, state_d;
    logic [STAGE_W-1:0]    stage_q, stage_d;
    logic [STAGE_W-1:0]    err_stage_q, err_stage_d;
    logic [1:0]            err_code_q, err_code_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic [31:0]           tot_q, tot_d;
    logic [NUM_STAGES-1:0] cur_mask;
    logic                  own_done, other_done;

    assign cur_mask   = NUM_STAGES'(1) << stage_q;
    assign own_done   = |(stage_done & cur_mask);
    assign other_done = |(stage_done & ~cur_mask);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            stage_q     <= '0;
            err_stage_q <= '0;
            err_code_q  <= ERR_NONE;
            wd_q        <= '0;
            tot_q       <= '0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            err_stage_q <= err_stage_d;
            err_code_q  <= err_code_d;
            wd_q        <= wd_d;
            tot_q       <= tot_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        err_stage_d = err_stage_q;
        err_code_d  = err_code_q;
        wd_d        = wd_q;
        tot_d       = tot_q;
        if ((state_q inside {S_LAUNCH, S_WAIT, S_FINISH}) && (tot_q != '1))
            tot_d = tot_q + 32'd1;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_LAUNCH;
                    stage_d = '0;
                    tot_d   = '0;
                end
            end
            S_LAUNCH: begin
                wd_d = '0;
                // An engine cannot legally finish in the cycle it is started.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (|stage_done) begin
                    state_d     = S_ERROR;
                    err_code_d  = ERR_SPURIOUS;
                    err_stage_d = stage_q;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                if (abort) begin
                    state_d = S_IDLE;
                end else if (other_done) begin
                    state_d     = S_ERROR;
                    err_code_d  = ERR_SPURIOUS;
                    err_stage_d = stage_q;
                end else if (own_done) begin
                    if (stage_q == LAST_STAGE) begin
                        state_d = S_FINISH;
                    end else begin
                        stage_d = stage_q + STAGE_W'(1);
                        state_d = S_LAUNCH;
                    end
                end else if (wd_q == WD_LIMIT) begin
                    state_d     = S_ERROR;
                    err_code_d  = ERR_TIMEOUT;
                    err_stage_d = stage_q;
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_ERROR: begin
                if (clear) begin
                    state_d    = S_IDLE;
                    err_code_d = ERR_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign stage_start  = (state_q == S_LAUNCH) ? cur_mask : '0;
    assign busy         = state_q inside {S_LAUNCH, S_WAIT, S_FINISH};
    assign done         = (state_q == S_FINISH);
    assign error        = (state_q == S_ERROR);
    assign err_code     = err_code_q;
    assign err_stage    = err_stage_q;
    assign cur_stage    = stage_q;
    assign total_cycles = tot_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized bench for layer_sequencer: per-run expectations are derived from
// stage latencies (start order, error cycle/code, busy-cycle totals).
module tb_layer_sequencer;
    localparam int NS = 3;
    localparam int TO = 16;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset, run, abort, clear;
    logic [NS-1:0] stage_done, stage_start;
    logic          busy, done, error;
    logic [1:0]    err_code;
    logic [SW-1:0] err_stage, cur_stage;
    logic [31:0]   total_cycles;
    int            n_cmp = 0;
    int            n_bad = 0;

    layer_sequencer #(.NUM_STAGES(NS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .run(run), .abort(abort), .clear(clear),
        .stage_done(stage_done), .stage_start(stage_start), .busy(busy),
        .done(done), .error(error), .err_code(err_code), .err_stage(err_stage),
        .cur_stage(cur_stage), .total_cycles(total_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Busy cycles consumed by fully completed stages 0..k-1.
    function automatic int prefix(input int lat[NS], input int k);
        int s = 0;
        for (int i = 0; i < k; i++) s += lat[i] + 1;
        return s;
    endfunction

    task automatic check_launch(input int k);
        chk($sformatf("launch%0d start", k), 32'(stage_start), 1 << k);
        chk($sformatf("launch%0d cur", k), 32'(cur_stage), k);
        chk($sformatf("launch%0d busy", k), 32'(busy), 1);
        chk($sformatf("launch%0d done", k), 32'(done), 0);
    endtask

    task automatic check_wait(input int k);
        chk($sformatf("wait%0d start", k), 32'(stage_start), 0);
        chk($sformatf("wait%0d busy", k), 32'(busy), 1);
        chk($sformatf("wait%0d error", k), 32'(error), 0);
        chk($sformatf("wait%0d done", k), 32'(done), 0);
    endtask

    task automatic check_err(input int code, input int k, input int tot);
        chk("err error", 32'(error), 1);
        chk("err code", 32'(err_code), code);
        chk("err stage", 32'(err_stage), k);
        chk("err busy", 32'(busy), 0);
        chk("err start", 32'(stage_start), 0);
        chk("err total", total_cycles, tot);
    endtask

    task automatic start_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic stage_normal(input int k, input int L);
        check_launch(k);
        tick();
        for (int j = 1; j <= L; j++) begin
            check_wait(k);
            if (j == L) stage_done = NS'(1 << k);
            tick();
            stage_done = '0;
        end
    endtask

    task automatic enter_stage(input int k, input int lat[NS]);
        start_run();
        for (int i = 0; i < k; i++) stage_normal(i, lat[i]);
    endtask

    task automatic clear_err();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr error", 32'(error), 0);
        chk("clr code", 32'(err_code), 0);
        chk("clr busy", 32'(busy), 0);
    endtask

    // Called at 1 time unit after an edge; reset lands mid-cycle.
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst start", 32'(stage_start), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst error", 32'(error), 0);
        chk("rst done", 32'(done), 0);
        chk("rst code", 32'(err_code), 0);
        chk("rst cur", 32'(cur_stage), 0);
        chk("rst total", total_cycles, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic run_ok(input int lat[NS]);
        enter_stage(NS, lat);
        chk("fin done", 32'(done), 1);
        chk("fin busy", 32'(busy), 1);
        chk("fin start", 32'(stage_start), 0);
        tick();
        chk("post done", 32'(done), 0);
        chk("post busy", 32'(busy), 0);
        chk("post total", total_cycles, prefix(lat, NS) + 1);
        tick();
        chk("idle total", total_cycles, prefix(lat, NS) + 1);
    endtask

    task automatic run_timeout(input int k, input int lat[NS]);
        enter_stage(k, lat);
        check_launch(k);
        tick();
        for (int j = 1; j <= TO; j++) begin
            check_wait(k);
            tick();
        end
        check_err(1, k, prefix(lat, k) + 1 + TO);
        run = 1'b1;
        tick();
        tick();
        run = 1'b0;
        chk("run ignored error", 32'(error), 1);
        chk("run ignored start", 32'(stage_start), 0);
        chk("run ignored busy", 32'(busy), 0);
        clear_err();
    endtask

    task automatic run_spur(input int k, input int at, input logic [NS-1:0] bits,
                            input int lat[NS], input bit use_reset);
        enter_stage(k, lat);
        check_launch(k);
        if (at == 0) stage_done = bits;
        tick();
        stage_done = '0;
        for (int j = 1; j <= at; j++) begin
            check_wait(k);
            if (j == at) stage_done = bits;
            tick();
            stage_done = '0;
        end
        check_err(2, k, prefix(lat, k) + 1 + at);
        if (use_reset) async_reset();
        else clear_err();
    endtask

    task automatic run_abort(input int k, input int at, input bit with_done, input int lat[NS]);
        enter_stage(k, lat);
        check_launch(k);
        if (at == 0) begin
            abort = 1'b1;
            if (with_done) stage_done = NS'(1 << k);
        end
        tick();
        abort = 1'b0;
        stage_done = '0;
        for (int j = 1; j <= at; j++) begin
            check_wait(k);
            if (j == at) begin
                abort = 1'b1;
                if (with_done) stage_done = NS'(1 << k);
            end
            tick();
            abort = 1'b0;
            stage_done = '0;
        end
        for (int j = 0; j < 3; j++) begin
            chk("abort start", 32'(stage_start), 0);
            chk("abort busy", 32'(busy), 0);
            chk("abort done", 32'(done), 0);
            chk("abort error", 32'(error), 0);
            chk("abort total", total_cycles, prefix(lat, k) + 1 + at);
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: still running at %0t, required to finish earlier", $time);
        $fatal(1, "bench time limit");
    end

    initial begin
        int            lat[NS];
        int            k, at, o, sel;
        logic [NS-1:0] bits;
        reset = 1'b0; run = 1'b0; abort = 1'b0; clear = 1'b0; stage_done = '0;
        #1 reset = 1'b1;
        #1;
        chk("reset start", 32'(stage_start), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset error", 32'(error), 0);
        chk("reset code", 32'(err_code), 0);
        chk("reset estage", 32'(err_stage), 0);
        chk("reset cur", 32'(cur_stage), 0);
        chk("reset total", total_cycles, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Idle ignores abort/clear/stage_done.
        abort = 1'b1; clear = 1'b1; stage_done = '1;
        tick();
        abort = 1'b0; clear = 1'b0; stage_done = '0;
        chk("idle ignore busy", 32'(busy), 0);
        chk("idle ignore error", 32'(error), 0);

        lat = '{4, 4, 4};
        run_ok(lat);
        chk("L4 total", total_cycles, 16);
        run_timeout(1, lat);
        run_ok(lat);
        lat = '{$urandom_range(1, TO), $urandom_range(1, TO), TO};
        run_ok(lat);
        run_spur(0, $urandom_range(1, TO), 3'b100, lat, 1'b0);
        run_spur(0, 0, 3'b001, lat, 1'b0);
        run_abort(1, $urandom_range(1, TO), 1'b0, lat);
        run_abort(1, $urandom_range(1, TO), 1'b1, lat);

        // Async reset in the middle of stage 1 WAIT.
        lat = '{3, 5, 2};
        enter_stage(1, lat);
        check_launch(1);
        tick();
        check_wait(1);
        tick();
        async_reset();
        run_ok(lat);

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NS; i++) lat[i] = $urandom_range(1, TO);
            k   = $urandom_range(0, NS - 1);
            sel = $urandom_range(0, 4);
            case (sel)
                0: run_ok(lat);
                1: run_timeout(k, lat);
                2: begin
                    at = $urandom_range(0, TO);
                    if (at == 0) begin
                        bits = NS'($urandom_range(1, (1 << NS) - 1));
                    end else begin
                        o    = (k + $urandom_range(1, NS - 1)) % NS;
                        bits = NS'(1 << o) | NS'($urandom);
                    end
                    run_spur(k, at, bits, lat, $urandom_range(0, 1) == 1);
                end
                default: run_abort(k, $urandom_range(0, TO), $urandom_range(0, 1) == 1, lat);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
